// File: rtl/cpu_consts.sv
// Shared CPU constants: access-size encodings, LSU state type and exception cause codes.
package cpu_consts;

  localparam logic [1:0] BYTE        = 2'd0;
  localparam logic [1:0] HALF_WORD   = 2'd1;
  localparam logic [1:0] WORD        = 2'd2;
  localparam logic [1:0] DOUBLE_WORD = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    DRAIN,
    RESP
  } lsu_state_t;

  localparam logic [4:0] EXC_LD_MISALIGN = 5'd4;
  localparam logic [4:0] EXC_LD_FAULT    = 5'd5;
  localparam logic [4:0] EXC_ST_MISALIGN = 5'd6;
  localparam logic [4:0] EXC_ST_FAULT    = 5'd7;

  function automatic logic [3:0] size_bytes(input logic [1:0] size);
    return 4'd1 << size;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte-lane steering for one memory row: store data shift and strobes, load extract and extend.
module lsu_lane_align
  import cpu_consts::*;
#(
  parameter int DATA_W = 64,
  localparam int STRB_W = DATA_W / 8,
  localparam int IDX_W = $clog2(STRB_W)
) (
  input  logic [IDX_W-1:0]  idx,
  input  logic [1:0]        size,
  input  logic              zero_extnd,
  input  logic [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0] wr_data_sh,
  output logic [STRB_W-1:0] strb,
  input  logic [DATA_W-1:0] rd_raw,
  output logic [DATA_W-1:0] rd_data
);

  logic [IDX_W+2:0]  shamt;
  logic [7:0]        size_mask;
  logic [7:0]        strb_full;
  logic [DATA_W-1:0] shifted;
  logic [DATA_W-1:0] keep;
  logic              sign;

  assign shamt      = {idx, 3'b000};
  assign wr_data_sh = wr_data << shamt;
  assign shifted    = rd_raw >> shamt;

  always_comb begin
    size_mask = 8'hFF;
    case (size)
      BYTE:      size_mask = 8'h01;
      HALF_WORD: size_mask = 8'h03;
      WORD:      size_mask = 8'h0F;
      default:   size_mask = 8'hFF;
    endcase
  end

  // Aligned accesses never push mask bits past the row, so truncation is lossless.
  assign strb_full = size_mask << idx;
  assign strb      = strb_full[STRB_W-1:0];

  always_comb begin
    keep = '1;
    sign = 1'b0;
    case (size)
      BYTE: begin
        keep = DATA_W'(8'hFF);
        sign = shifted[7];
      end
      HALF_WORD: begin
        keep = DATA_W'(16'hFFFF);
        sign = shifted[15];
      end
      WORD: begin
        keep = DATA_W'(32'hFFFF_FFFF);
        sign = shifted[31];
      end
      default: begin
        keep = '1;
        sign = 1'b0;
      end
    endcase
  end

  // A full-row access has keep all ones, so both branches agree and the extend flag is moot.
  assign rd_data = (zero_extnd || !sign) ? (shifted & keep) : (shifted | ~keep);

endmodule

// File: rtl/lsu_mem_access.sv
// Memory-stage load/store unit: one transaction in flight to a variable-latency data memory.
module lsu_mem_access
  import cpu_consts::*;
#(
  parameter int                ADDR_W   = 64,
  parameter int                DATA_W   = 64,
  parameter logic [ADDR_W-1:0] MEM_BASE = '0,
  parameter longint unsigned   MEM_SIZE = 512 * 1024,
  localparam int STRB_W = DATA_W / 8,
  localparam int IDX_W  = $clog2(STRB_W)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [1:0]        req_size_i,
  input  logic              req_wr_i,
  input  logic [DATA_W-1:0] req_wr_data_i,
  input  logic              req_zero_extnd_i,
  input  logic              flush_i,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_wr_o,
  output logic [DATA_W-1:0] mem_wr_data_o,
  output logic [STRB_W-1:0] mem_byte_strb_o,
  input  logic              mem_rsp_valid_i,
  input  logic [DATA_W-1:0] mem_rsp_data_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              rsp_exc_valid_o,
  output logic [4:0]        rsp_exc_code_o,
  output lsu_state_t        dbg_state
);

  // Handshakes: a transfer happens on a cycle where valid & ready are both high; the
  // valid side holds its payload stable until then and the ready side may stall freely.
  lsu_state_t        state;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic              wr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              zext_q;
  logic              exc_q;
  logic [4:0]        exc_code_q;
  logic [DATA_W-1:0] rdata_q;

  logic [ADDR_W:0]   below_base;
  logic [ADDR_W:0]   req_end;
  logic [ADDR_W:0]   region_end;
  logic              misalign;
  logic              fault;
  logic              req_exc;
  logic [4:0]        req_exc_code;
  logic [DATA_W-1:0] wr_data_sh;
  logic [STRB_W-1:0] strb;
  logic [DATA_W-1:0] ld_data;
  logic              issuing;
  logic              rsp_fire;

  // One extra bit: a borrow flags addr < base, a carry flags wrap past the top of memory.
  assign below_base = {1'b0, req_addr_i} - {1'b0, MEM_BASE};
  assign req_end    = {1'b0, req_addr_i} + (ADDR_W+1)'(size_bytes(req_size_i));
  assign region_end = {1'b0, MEM_BASE} + (ADDR_W+1)'(MEM_SIZE);

  always_comb begin
    misalign = 1'b0;
    case (req_size_i)
      HALF_WORD:   misalign = req_addr_i[0];
      WORD:        misalign = |req_addr_i[1:0];
      DOUBLE_WORD: misalign = (DATA_W == 32) || (|req_addr_i[2:0]);
      default:     misalign = 1'b0;
    endcase
  end

  assign fault        = below_base[ADDR_W] || (req_end > region_end);
  assign req_exc      = misalign || fault;
  assign req_exc_code = req_wr_i ? (misalign ? EXC_ST_MISALIGN : EXC_ST_FAULT)
                                 : (misalign ? EXC_LD_MISALIGN : EXC_LD_FAULT);

  lsu_lane_align #(.DATA_W(DATA_W)) u_lane_align (
    .idx        (addr_q[IDX_W-1:0]),
    .size       (size_q),
    .zero_extnd (zext_q),
    .wr_data    (wr_data_q),
    .wr_data_sh (wr_data_sh),
    .strb       (strb),
    .rd_raw     (mem_rsp_data_i),
    .rd_data    (ld_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      size_q     <= BYTE;
      wr_q       <= 1'b0;
      wr_data_q  <= '0;
      zext_q     <= 1'b0;
      exc_q      <= 1'b0;
      exc_code_q <= '0;
      rdata_q    <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid_i) begin
          addr_q     <= req_addr_i;
          size_q     <= req_size_i;
          wr_q       <= req_wr_i;
          wr_data_q  <= req_wr_data_i;
          zext_q     <= req_zero_extnd_i;
          exc_q      <= req_exc;
          exc_code_q <= req_exc ? req_exc_code : 5'd0;
          rdata_q    <= '0;
          state      <= req_exc ? RESP : ISSUE;
        end
        // A flush racing the memory handshake still owes the memory its load response.
        ISSUE: begin
          if (mem_req_ready_i) begin
            if (flush_i) state <= wr_q ? IDLE : DRAIN;
            else         state <= wr_q ? RESP : WAIT;
          end else if (flush_i) begin
            state <= IDLE;
          end
        end
        WAIT: begin
          if (mem_rsp_valid_i) begin
            if (flush_i) begin
              state <= IDLE;
            end else begin
              rdata_q <= ld_data;
              state   <= RESP;
            end
          end else if (flush_i) begin
            state <= DRAIN;
          end
        end
        DRAIN: if (mem_rsp_valid_i) state <= IDLE;
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign issuing  = (state == ISSUE);
  assign rsp_fire = (state == RESP) && !flush_i;

  assign req_ready_o     = (state == IDLE);
  assign mem_req_valid_o = issuing;
  assign mem_addr_o      = issuing ? {addr_q[ADDR_W-1:IDX_W], {IDX_W{1'b0}}} : '0;
  assign mem_wr_o        = issuing && wr_q;
  assign mem_wr_data_o   = (issuing && wr_q) ? wr_data_sh : '0;
  assign mem_byte_strb_o = (issuing && wr_q) ? strb : '0;
  assign rsp_valid_o     = rsp_fire;
  assign rsp_data_o      = rsp_fire ? rdata_q : '0;
  assign rsp_exc_valid_o = rsp_fire && exc_q;
  assign rsp_exc_code_o  = (rsp_fire && exc_q) ? exc_code_q : 5'd0;
  assign dbg_state       = state;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed bench for lsu_mem_access: vector table through a zero/stall-wait memory plus flush/reset sequences.
module tb_lsu_mem_access;
  import cpu_consts::*;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid_i;
  logic              req_ready_o;
  logic [ADDR_W-1:0] req_addr_i;
  logic [1:0]        req_size_i;
  logic              req_wr_i;
  logic [DATA_W-1:0] req_wr_data_i;
  logic              req_zero_extnd_i;
  logic              flush_i;
  logic              mem_req_valid_o;
  logic              mem_req_ready_i;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_wr_o;
  logic [DATA_W-1:0] mem_wr_data_o;
  logic [7:0]        mem_byte_strb_o;
  logic              mem_rsp_valid_i;
  logic [DATA_W-1:0] mem_rsp_data_i;
  logic              rsp_valid_o;
  logic [DATA_W-1:0] rsp_data_o;
  logic              rsp_exc_valid_o;
  logic [4:0]        rsp_exc_code_o;
  lsu_state_t        dbg_state;

  int checks = 0;
  int errors = 0;
  int rsp_cnt = 0;

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic        zext;
    logic [63:0] raw;
    int          lat;
    logic [4:0]  code;
    logic [63:0] rdata;
    logic [63:0] maddr;
    logic [7:0]  strb;
    logic [63:0] mwdata;
  } vec_t;

  vec_t vecs[16];

  lsu_mem_access dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid_i      (req_valid_i),
    .req_ready_o      (req_ready_o),
    .req_addr_i       (req_addr_i),
    .req_size_i       (req_size_i),
    .req_wr_i         (req_wr_i),
    .req_wr_data_i    (req_wr_data_i),
    .req_zero_extnd_i (req_zero_extnd_i),
    .flush_i          (flush_i),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_addr_o       (mem_addr_o),
    .mem_wr_o         (mem_wr_o),
    .mem_wr_data_o    (mem_wr_data_o),
    .mem_byte_strb_o  (mem_byte_strb_o),
    .mem_rsp_valid_i  (mem_rsp_valid_i),
    .mem_rsp_data_i   (mem_rsp_data_i),
    .rsp_valid_o      (rsp_valid_o),
    .rsp_data_o       (rsp_data_o),
    .rsp_exc_valid_o  (rsp_exc_valid_o),
    .rsp_exc_code_o   (rsp_exc_code_o),
    .dbg_state        (dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) if (rsp_valid_o) rsp_cnt++;

  // Scoreboard check
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, " req_ready"}, req_ready_o, 1);
    chk({tag, " mem_req_valid"}, mem_req_valid_o, 0);
    chk({tag, " mem_addr"}, mem_addr_o, 0);
    chk({tag, " mem_wr"}, mem_wr_o, 0);
    chk({tag, " mem_wr_data"}, mem_wr_data_o, 0);
    chk({tag, " mem_strb"}, mem_byte_strb_o, 0);
    chk({tag, " rsp_valid"}, rsp_valid_o, 0);
    chk({tag, " rsp_data"}, rsp_data_o, 0);
    chk({tag, " exc_valid"}, rsp_exc_valid_o, 0);
    chk({tag, " exc_code"}, rsp_exc_code_o, 0);
  endtask

  task automatic drive_req(input vec_t v);
    req_valid_i      = 1'b1;
    req_addr_i       = v.addr;
    req_size_i       = v.size;
    req_wr_i         = v.wr;
    req_wr_data_i    = v.wdata;
    req_zero_extnd_i = v.zext;
    mem_rsp_data_i   = v.raw;
  endtask

  // Driver + memory model: stalls mem_req_ready_i for 'stall' cycles, answers loads one cycle after handshake
  task automatic run_vec(input vec_t v, input int stall, input string tag);
    int cyc;
    bit done;
    bit mem_seen;
    bit rsp_next;
    int stall_left;
    stall_left = stall;
    done = 0;
    mem_seen = 0;
    rsp_next = 0;
    @(negedge clk);
    drive_req(v);
    #1 chk({tag, " accept_ready"}, req_ready_o, 1);
    @(negedge clk);
    req_valid_i = 1'b0;
    cyc = 1;
    while (!done && cyc <= 20) begin
      mem_rsp_valid_i = rsp_next;
      rsp_next = 0;
      mem_req_ready_i = 1'b0;
      #1;
      if (mem_req_valid_o) begin
        mem_seen = 1;
        chk({tag, " mem_addr"}, mem_addr_o, v.maddr);
        chk({tag, " mem_wr"}, mem_wr_o, v.wr);
        chk({tag, " busy_ready"}, req_ready_o, 0);
        if (v.wr) begin
          chk({tag, " mem_strb"}, mem_byte_strb_o, v.strb);
          chk({tag, " mem_wdata"}, mem_wr_data_o, v.mwdata);
        end
        if (stall_left > 0) stall_left--;
        else begin
          mem_req_ready_i = 1'b1;
          rsp_next = !v.wr;
        end
      end
      if (rsp_valid_o) begin
        done = 1;
        chk({tag, " latency"}, cyc, v.lat + stall);
        chk({tag, " exc_valid"}, rsp_exc_valid_o, v.code != 0);
        chk({tag, " exc_code"}, rsp_exc_code_o, v.code);
        chk({tag, " rsp_data"}, rsp_data_o, v.rdata);
      end
      @(negedge clk);
      cyc++;
    end
    mem_rsp_valid_i = 1'b0;
    mem_req_ready_i = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout actual=no_rsp expected=rsp_valid", tag);
    end
    #1;
    chk({tag, " pulse_end"}, rsp_valid_o, 0);
    chk({tag, " idle_ready"}, req_ready_o, 1);
    chk({tag, " mem_access"}, mem_seen, v.code == 0);
  endtask

  // Bring a load into WAIT: returns at the negedge of the WAIT cycle
  task automatic load_to_wait(input logic [63:0] addr);
    vec_t v;
    v = '{1'b0, WORD, addr, 64'h0, 1'b0, 64'h1234_5678_9ABC_DEF0, 3, 5'd0, 64'h0, 64'h0, 8'h0, 64'h0};
    @(negedge clk);
    drive_req(v);
    @(negedge clk);
    req_valid_i = 1'b0;
    mem_req_ready_i = 1'b1;
    #1 chk("seq issue", mem_req_valid_o, 1);
    @(negedge clk);
    mem_req_ready_i = 1'b0;
    #1 chk("seq wait_state", dbg_state, WAIT);
  endtask

  initial begin
    int cnt0;
    vecs[0]  = '{1'b1, WORD,        64'h104, 64'hDEADBEEF, 1'b0, 64'h0, 2, 5'd0, 64'h0, 64'h100, 8'hF0, 64'hDEADBEEF_00000000};
    vecs[1]  = '{1'b0, BYTE,        64'h7, 64'h0, 1'b0, 64'h8011_2233_4455_6677, 3, 5'd0, 64'hFFFF_FFFF_FFFF_FF80, 64'h0, 8'h0, 64'h0};
    vecs[2]  = '{1'b0, BYTE,        64'h7, 64'h0, 1'b1, 64'h8011_2233_4455_6677, 3, 5'd0, 64'h80, 64'h0, 8'h0, 64'h0};
    vecs[3]  = '{1'b0, HALF_WORD,   64'h3, 64'h0, 1'b0, 64'h0, 1, 5'd4, 64'h0, 64'h0, 8'h0, 64'h0};
    vecs[4]  = '{1'b1, DOUBLE_WORD, 64'h80000, 64'h55, 1'b0, 64'h0, 1, 5'd7, 64'h0, 64'h0, 8'h0, 64'h0};
    vecs[5]  = '{1'b1, HALF_WORD,   64'h1, 64'h55, 1'b0, 64'h0, 1, 5'd6, 64'h0, 64'h0, 8'h0, 64'h0};
    vecs[6]  = '{1'b0, WORD,        64'h7FFFC, 64'h0, 1'b0, 64'hCAFEBABE_12345678, 3, 5'd0, 64'hFFFF_FFFF_CAFE_BABE, 64'h7FFF8, 8'h0, 64'h0};
    vecs[7]  = '{1'b0, WORD,        64'h80000, 64'h0, 1'b0, 64'h0, 1, 5'd5, 64'h0, 64'h0, 8'h0, 64'h0};
    vecs[8]  = '{1'b1, BYTE,        64'h5, 64'hAB, 1'b0, 64'h0, 2, 5'd0, 64'h0, 64'h0, 8'h20, 64'h0000_AB00_0000_0000};
    vecs[9]  = '{1'b0, DOUBLE_WORD, 64'h10, 64'h0, 1'b0, 64'h0123_4567_89AB_CDEF, 3, 5'd0, 64'h0123_4567_89AB_CDEF, 64'h10, 8'h0, 64'h0};
    vecs[10] = '{1'b0, HALF_WORD,   64'h6, 64'h0, 1'b0, 64'h8001_0000_0000_0000, 3, 5'd0, 64'hFFFF_FFFF_FFFF_8001, 64'h0, 8'h0, 64'h0};
    vecs[11] = '{1'b1, DOUBLE_WORD, 64'h8, 64'h1122_3344_5566_7788, 1'b0, 64'h0, 2, 5'd0, 64'h0, 64'h8, 8'hFF, 64'h1122_3344_5566_7788};
    vecs[12] = '{1'b0, WORD,        64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 1'b0, 64'h0, 1, 5'd5, 64'h0, 64'h0, 8'h0, 64'h0};
    vecs[13] = '{1'b1, WORD,        64'h80001, 64'h0, 1'b0, 64'h0, 1, 5'd6, 64'h0, 64'h0, 8'h0, 64'h0};
    vecs[14] = '{1'b0, HALF_WORD,   64'h2, 64'h0, 1'b1, 64'h0000_0000_F00D_0000, 3, 5'd0, 64'hF00D, 64'h0, 8'h0, 64'h0};
    vecs[15] = '{1'b1, HALF_WORD,   64'h7FFFE, 64'h1234, 1'b0, 64'h0, 2, 5'd0, 64'h0, 64'h7FFF8, 8'hC0, 64'h1234_0000_0000_0000};

    reset = 1'b1;
    req_valid_i = 1'b0;
    req_addr_i = '0;
    req_size_i = BYTE;
    req_wr_i = 1'b0;
    req_wr_data_i = '0;
    req_zero_extnd_i = 1'b0;
    flush_i = 1'b0;
    mem_req_ready_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    mem_rsp_data_i = '0;
    repeat (2) @(negedge clk);
    #1 chk_reset_outputs("por");
    chk("por state", dbg_state, IDLE);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) run_vec(vecs[i], 0, $sformatf("vec%0d", i));

    // Memory stalls five cycles while the store waits in ISSUE
    run_vec(vecs[0], 5, "stall");

    // Flush during RESP drops the completion pulse
    @(negedge clk);
    drive_req(vecs[3]);
    @(negedge clk);
    req_valid_i = 1'b0;
    flush_i = 1'b1;
    #1 chk("flush_resp rsp_valid", rsp_valid_o, 0);
    @(negedge clk);
    flush_i = 1'b0;
    #1 chk("flush_resp ready", req_ready_o, 1);

    // Flush in WAIT, response three cycles later; a pending request must wait for the drain
    cnt0 = rsp_cnt;
    load_to_wait(64'h100);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    drive_req(vecs[8]);
    #1 chk("drain c1 ready", req_ready_o, 0);
    @(negedge clk);
    #1 chk("drain c2 ready", req_ready_o, 0);
    @(negedge clk);
    mem_rsp_valid_i = 1'b1;
    #1 chk("drain c3 ready", req_ready_o, 0);
    @(negedge clk);
    mem_rsp_valid_i = 1'b0;
    req_valid_i = 1'b0;
    #1 chk("drain done ready", req_ready_o, 1);
    chk("drain no rsp", rsp_cnt, cnt0);
    run_vec(vecs[8], 0, "after_drain");

    // Flush coincident with the memory response returns straight to IDLE
    cnt0 = rsp_cnt;
    load_to_wait(64'h200);
    flush_i = 1'b1;
    mem_rsp_valid_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    mem_rsp_valid_i = 1'b0;
    #1 chk("flush_rsp ready", req_ready_o, 1);
    chk("flush_rsp state", dbg_state, IDLE);
    @(negedge clk);
    chk("flush_rsp no rsp", rsp_cnt, cnt0);

    // Reset in WAIT aborts at once; a stray response afterward is ignored
    cnt0 = rsp_cnt;
    load_to_wait(64'h300);
    reset = 1'b1;
    #1 chk_reset_outputs("rst_wait");
    @(negedge clk);
    reset = 1'b0;
    mem_rsp_valid_i = 1'b1;
    @(negedge clk);
    mem_rsp_valid_i = 1'b0;
    #1 chk("rst stray ready", req_ready_o, 1);
    @(negedge clk);
    #1 chk("rst stray rsp_valid", rsp_valid_o, 0);
    chk("rst stray no rsp", rsp_cnt, cnt0);
    run_vec(vecs[1], 0, "after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
